// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD sweep sequencer and its pair counter.
//   - default operand width and sweep limit
//   - default WAIT timeout and coprime counter width
//   - sequencer state encoding
package gcd_pkg;

    localparam int GCD_W       = 7;
    localparam int GCD_MAX     = 15;
    localparam int GCD_TIMEOUT = 1024;
    localparam int GCD_CNT_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_REPORT = 3'd3,
        ST_PAUSE  = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_e;

endpackage

// File: rtl/gcd_pair_counter.sv
// Nested operand counter for the sweep: b runs 1..MAX fastest, a steps when b wraps.
// Ports:
//   clk     in  system clock, rising edge
//   rst_n   in  asynchronous reset, active low; loads (1,1)
//   clr_i   in  reload (1,1); wins over inc_i
//   inc_i   in  advance to the next pair (row-major)
//   a_o     out current operand a (register output)
//   b_o     out current operand b (register output)
//   last_o  out current pair is (MAX,MAX)
module gcd_pair_counter
    import gcd_pkg::*;
#(
    parameter int W   = GCD_W,
    parameter int MAX = GCD_MAX
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o,
    output logic         last_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W-1:0] ONE_V = W'(1);

    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (clr_i) begin
            a_d = ONE_V;
            b_d = ONE_V;
        end else if (inc_i) begin
            if (b_q == MAX_V) begin
                b_d = ONE_V;
                // Wrapping after the last pair leaves the counter parked at (1,1).
                a_d = (a_q == MAX_V) ? ONE_V : a_q + ONE_V;
            end else begin
                b_d = b_q + ONE_V;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= ONE_V;
            b_q <= ONE_V;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign a_o    = a_q;
    assign b_o    = b_q;
    assign last_o = (a_q == MAX_V) && (b_q == MAX_V);

endmodule

// File: rtl/gcd_sweep_sequencer.sv
// Initiator for the GCD core: sweeps (a,b) over 1..MAX x 1..MAX, issues each pair
// with a start/done handshake, reports each result and counts coprime pairs.
// Every output is a register.
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous reset, active low
//   run          in   1 = sweep/resume, 0 = pause after the current pair
//   gcd_start    out  one-cycle start pulse to the core
//   gcd_a/gcd_b  out  operands, stable from ISSUE until WAIT exits
//   gcd_done     in   core done level
//   gcd_result   in   core result, valid while gcd_done=1
//   res_valid    out  one-cycle pulse with res_a/res_b/res_gcd
//   coprime_cnt  out  saturating count of reported pairs with gcd == 1
//   busy         out  1 in ISSUE, WAIT, REPORT
//   sweep_done   out  1 in DONE
//   err          out  sticky WAIT timeout flag
//
// state  | meaning
// IDLE   | waiting for run; pair counter reloads to (1,1) on exit
// ISSUE  | waiting for stale done to drop, then fires start
// WAIT   | waiting for done; timer bounds the wait
// REPORT | one-cycle result report, pair advance
// PAUSE  | run low between pairs, everything held
// DONE   | sweep finished or timed out; waiting for run low
module gcd_sweep_sequencer
    import gcd_pkg::*;
#(
    parameter int W       = GCD_W,
    parameter int MAX     = GCD_MAX,
    parameter int TIMEOUT = GCD_TIMEOUT,
    parameter int CNT_W   = GCD_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic             gcd_start,
    output logic [W-1:0]     gcd_a,
    output logic [W-1:0]     gcd_b,
    input  logic             gcd_done,
    input  logic [W-1:0]     gcd_result,
    output logic             res_valid,
    output logic [W-1:0]     res_a,
    output logic [W-1:0]     res_b,
    output logic [W-1:0]     res_gcd,
    output logic [CNT_W-1:0] coprime_cnt,
    output logic             busy,
    output logic             sweep_done,
    output logic             err
);

    localparam int               TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

    seq_state_e state_q, state_d;

    logic [TMR_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             sdone_q, sdone_d;
    logic             err_q, err_d;
    logic             rvalid_q, rvalid_d;
    logic [W-1:0]     res_a_q, res_a_d;
    logic [W-1:0]     res_b_q, res_b_d;
    logic [W-1:0]     res_gcd_q, res_gcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [W-1:0] pair_a, pair_b;
    logic         pair_last;
    logic         pair_clr, pair_inc;
    logic         done_seen, timeout_hit;

    assign pair_clr = (state_q == ST_IDLE) && run;
    assign pair_inc = (state_q == ST_REPORT);

    gcd_pair_counter #(
        .W   (W),
        .MAX (MAX)
    ) u_pair (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (pair_clr),
        .inc_i  (pair_inc),
        .a_o    (pair_a),
        .b_o    (pair_b),
        .last_o (pair_last)
    );

    // Timer holds the load value outside WAIT, so it is fresh on every entry.
    // The load value marks the first WAIT cycle, in which done is not trusted.
    assign done_seen   = gcd_done && (wait_cnt_q != TMR_LOAD);
    assign timeout_hit = (wait_cnt_q == '0);

    always_comb begin
        wait_cnt_d = TMR_LOAD;
        if (state_q == ST_WAIT && !timeout_hit) begin
            wait_cnt_d = wait_cnt_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (run) state_d = ST_ISSUE;
            ST_ISSUE:  if (!gcd_done) state_d = ST_WAIT;
            ST_WAIT: begin
                if (done_seen) begin
                    state_d = ST_REPORT;
                end else if (timeout_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_REPORT: begin
                if (pair_last) begin
                    state_d = ST_DONE;
                end else if (run) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE:  if (run) state_d = ST_ISSUE;
            ST_DONE:   if (!run) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state so the registers line up
    // with the state they describe.
    always_comb begin
        start_d   = (state_q == ST_ISSUE) && (state_d == ST_WAIT);
        busy_d    = (state_d == ST_ISSUE) || (state_d == ST_WAIT) || (state_d == ST_REPORT);
        sdone_d   = (state_d == ST_DONE);
        rvalid_d  = (state_d == ST_REPORT);
        res_a_d   = res_a_q;
        res_b_d   = res_b_q;
        res_gcd_d = res_gcd_q;
        cnt_d     = cnt_q;
        err_d     = err_q;

        if (state_q == ST_IDLE && state_d == ST_ISSUE) begin
            cnt_d = '0;
            err_d = 1'b0;
        end

        if (state_q == ST_WAIT && state_d == ST_REPORT) begin
            res_a_d   = pair_a;
            res_b_d   = pair_b;
            res_gcd_d = gcd_result;
            if (gcd_result == W'(1) && cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (state_q == ST_WAIT && state_d == ST_DONE) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= TMR_LOAD;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            sdone_q    <= 1'b0;
            err_q      <= 1'b0;
            rvalid_q   <= 1'b0;
            res_a_q    <= '0;
            res_b_q    <= '0;
            res_gcd_q  <= '0;
            cnt_q      <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            sdone_q    <= sdone_d;
            err_q      <= err_d;
            rvalid_q   <= rvalid_d;
            res_a_q    <= res_a_d;
            res_b_q    <= res_b_d;
            res_gcd_q  <= res_gcd_d;
            cnt_q      <= cnt_d;
        end
    end

    assign gcd_start   = start_q;
    assign gcd_a       = pair_a;
    assign gcd_b       = pair_b;
    assign res_valid   = rvalid_q;
    assign res_a       = res_a_q;
    assign res_b       = res_b_q;
    assign res_gcd     = res_gcd_q;
    assign coprime_cnt = cnt_q;
    assign busy        = busy_q;
    assign sweep_done  = sdone_q;
    assign err         = err_q;

endmodule

// File: tb/tb_gcd_sweep_sequencer.sv
`timescale 1ns/1ps
module tb_gcd_sweep_sequencer;

    localparam int W       = 7;
    localparam int MAX     = 15;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 8;
    localparam int BUDGET  = 5000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             run = 1'b0;
    logic             gcd_start;
    logic [W-1:0]     gcd_a, gcd_b;
    logic             gcd_done = 1'b0;
    logic [W-1:0]     gcd_result = '0;
    logic             res_valid;
    logic [W-1:0]     res_a, res_b, res_gcd;
    logic [CNT_W-1:0] coprime_cnt;
    logic             busy, sweep_done, err;

    always #5 clk = ~clk;

    gcd_sweep_sequencer #(
        .W       (W),
        .MAX     (MAX),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .gcd_start   (gcd_start),
        .gcd_a       (gcd_a),
        .gcd_b       (gcd_b),
        .gcd_done    (gcd_done),
        .gcd_result  (gcd_result),
        .res_valid   (res_valid),
        .res_a       (res_a),
        .res_b       (res_b),
        .res_gcd     (res_gcd),
        .coprime_cnt (coprime_cnt),
        .busy        (busy),
        .sweep_done  (sweep_done),
        .err         (err)
    );

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] g;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   exp_cnt   = 0;
    int   start_cnt = 0;
    int   res_cnt   = 0;
    bit   core_mute = 1'b0;
    int   core_hold = 0;
    int   lat       = 0;
    int   hold_left = 0;

    function automatic int ref_gcd(input int x, input int y);
        int p = x;
        int q = y;
        int t;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push(input int a, input int b);
        exp_t x;
        x.a = W'(a);
        x.b = W'(b);
        x.g = W'(ref_gcd(a, b));
        sb.push_back(x);
    endtask

    // Core model: done 3 cycles after start, optionally held core_hold extra cycles.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcd_done  = 1'b0;
            lat       = 0;
            hold_left = 0;
        end else if (gcd_start) begin
            lat        = 3;
            gcd_result = W'(ref_gcd(int'(gcd_a), int'(gcd_b)));
            gcd_done   = 1'b0;
        end else if (lat > 0) begin
            lat--;
            if (lat == 0 && !core_mute) begin
                gcd_done  = 1'b1;
                hold_left = core_hold;
            end
        end else if (gcd_done) begin
            if (hold_left > 0) hold_left--;
            else gcd_done = 1'b0;
        end
    end

    // Monitor / scoreboard
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (gcd_start === 1'b1) begin
                start_cnt++;
                check("start_while_done", gcd_done, 0);
            end
            if (res_valid === 1'b1) begin
                res_cnt++;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_res_valid: got pair (%0d,%0d), expected none", res_a, res_b);
                end else begin
                    e = sb.pop_front();
                    check("res_a", res_a, e.a);
                    check("res_b", res_b, e.b);
                    check("res_gcd", res_gcd, e.g);
                    if (e.g == W'(1) && exp_cnt < 255) exp_cnt++;
                    check("coprime_cnt_run", coprime_cnt, exp_cnt);
                    if (e.a == W'(12) && e.b == W'(8)) check("gcd_12_8", res_gcd, 4);
                    if (e.a == W'(7) && e.b == W'(15)) check("gcd_7_15", res_gcd, 1);
                end
            end
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        run       = 1'b0;
        core_mute = 1'b0;
        core_hold = 0;
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 0;
        sb.delete();
        @(negedge clk);
    endtask

    task automatic wait_any_start(input string name);
        int n = 0;
        while (gcd_start !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check(name, (n < BUDGET), 1);
    endtask

    task automatic wait_start_pair(input int a, input int b, input string name);
        int n = 0;
        while (!(gcd_start === 1'b1 && gcd_a == W'(a) && gcd_b == W'(b)) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check(name, (n < BUDGET), 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check(name, (n < BUDGET), 1);
    endtask

    initial begin
        int sc, rc, n;

        // Reset state and full sweep
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_start", gcd_start, 0);
        check("rst_gcd_a", gcd_a, 1);
        check("rst_gcd_b", gcd_b, 1);
        check("rst_sweep_done", sweep_done, 0);
        check("rst_err", err, 0);
        check("rst_coprime", coprime_cnt, 0);
        check("rst_res_valid", res_valid, 0);
        for (int a = 1; a <= MAX; a++)
            for (int b = 1; b <= MAX; b++)
                push(a, b);
        sc  = start_cnt;
        rc  = res_cnt;
        run = 1'b1;
        n   = 0;
        while (sweep_done !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("sweep_finished", (n < BUDGET), 1);
        check("sweep_done", sweep_done, 1);
        check("sweep_err", err, 0);
        check("sweep_coprime", coprime_cnt, 143);
        check("sweep_reports", res_cnt - rc, 225);
        check("sweep_starts", start_cnt - sc, 225);
        check("sweep_sb_empty", sb.size(), 0);
        check("done_res_a", res_a, 15);
        check("done_res_b", res_b, 15);
        check("done_res_gcd", res_gcd, 15);
        check("done_busy", busy, 0);
        run = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_sweep_done", sweep_done, 0);
        check("idle_coprime_held", coprime_cnt, 143);
        exp_cnt = 0;
        push(1, 1);
        run = 1'b1;
        wait_any_start("restart_start");
        check("restart_a", gcd_a, 1);
        check("restart_b", gcd_b, 1);
        check("restart_cnt_clr", coprime_cnt, 0);
        run = 1'b0;
        wait_idle("restart_idle");
        check("restart_sb_empty", sb.size(), 0);

        // run dropped during WAIT of (2,5)
        do_reset();
        for (int b = 1; b <= 15; b++) push(1, b);
        for (int b = 1; b <= 5; b++) push(2, b);
        run = 1'b1;
        wait_start_pair(2, 5, "start_2_5");
        run = 1'b0;
        wait_idle("pause_reached");
        check("pause_a", gcd_a, 2);
        check("pause_b", gcd_b, 6);
        check("pause_res_a", res_a, 2);
        check("pause_res_b", res_b, 5);
        check("pause_coprime", coprime_cnt, 18);
        check("pause_sweep_done", sweep_done, 0);
        check("pause_sb_empty", sb.size(), 0);
        sc = start_cnt;
        repeat (8) @(negedge clk);
        check("pause_no_start", start_cnt - sc, 0);
        push(2, 6);
        run = 1'b1;
        wait_any_start("resume_start");
        check("resume_a", gcd_a, 2);
        check("resume_b", gcd_b, 6);
        run = 1'b0;
        wait_idle("resume_idle");
        check("resume_sb_empty", sb.size(), 0);

        // Core never answers
        do_reset();
        core_mute = 1'b1;
        rc  = res_cnt;
        run = 1'b1;
        wait_any_start("to_start");
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("to_wait_cycles", n, 16);
        check("to_err", err, 1);
        check("to_sweep_done", sweep_done, 1);
        check("to_no_report", res_cnt - rc, 0);
        check("to_coprime", coprime_cnt, 0);
        run       = 1'b0;
        core_mute = 1'b0;
        repeat (2) @(negedge clk);
        check("to_idle_done", sweep_done, 0);
        check("to_err_sticky", err, 1);
        exp_cnt = 0;
        push(1, 1);
        run = 1'b1;
        wait_any_start("to_restart");
        check("to_err_cleared", err, 0);
        run = 1'b0;
        wait_idle("to_restart_idle");
        check("to_sb_empty", sb.size(), 0);

        // Core holds done 4 extra cycles
        do_reset();
        core_hold = 4;
        push(1, 1);
        push(1, 2);
        push(1, 3);
        sc  = start_cnt;
        rc  = res_cnt;
        run = 1'b1;
        wait_start_pair(1, 3, "hold_start_1_3");
        run = 1'b0;
        wait_idle("hold_idle");
        check("hold_starts", start_cnt - sc, 3);
        check("hold_reports", res_cnt - rc, 3);
        check("hold_sb_empty", sb.size(), 0);

        // Async reset in the middle of WAIT
        do_reset();
        push(1, 1);
        push(1, 2);
        run = 1'b1;
        wait_start_pair(1, 3, "rst_mid_start");
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_start", gcd_start, 0);
        check("arst_busy", busy, 0);
        check("arst_gcd_a", gcd_a, 1);
        check("arst_gcd_b", gcd_b, 1);
        check("arst_coprime", coprime_cnt, 0);
        check("arst_res_gcd", res_gcd, 0);
        check("arst_res_b", res_b, 0);
        check("arst_sb_empty", sb.size(), 0);
        run = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
        push(1, 1);
        push(1, 2);
        run = 1'b1;
        wait_any_start("arst_restart");
        check("arst_restart_a", gcd_a, 1);
        check("arst_restart_b", gcd_b, 1);
        check("arst_restart_cnt", coprime_cnt, 0);
        wait_start_pair(1, 2, "arst_start_1_2");
        run = 1'b0;
        wait_idle("arst_idle");
        check("arst_final_cnt", coprime_cnt, 2);
        check("arst_final_sb", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected summary before 500000ns");
        $fatal(1, "watchdog");
    end

endmodule
